// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;
  localparam int BYTE_W              = 8;
  localparam int N_REQ_DEFAULT       = 4;
  localparam int MAX_PKT_LEN_DEFAULT = 256;
  localparam int CNT_W               = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping modulo N; ptr itself has the lowest priority.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding N byte streams into one UART TX buffer,
// at most one byte per two clocks, with forced release at MAX_PKT_LEN bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEFAULT,
  parameter  int MAX_PKT_LEN = MAX_PKT_LEN_DEFAULT,
  localparam int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]         tx_data_in,
  output logic                      write_tx_data,
  input  logic                      tx_buffer_full,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      pkt_abort
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                abort_q, abort_d;
  logic                end_q, end_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [BYTE_W-1:0]   sel_data;
  logic                sel_last;
  logic                xfer;
  logic [CNT_W-1:0]    cnt_inc;
  logic                at_max;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_data = req_data[i*BYTE_W +: BYTE_W];
        sel_last = req_last[i];
      end
    end
  end

  assign xfer    = (state_q == ST_XFER) & req_valid[grant_q] & req_ready[grant_q];
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign at_max  = (cnt_inc == CNT_W'(MAX_PKT_LEN));

  // Every flop, including the control state, is cleared so a reset mid-packet drops it cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      abort_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      abort_q  <= abort_d;
      end_q    <= end_d;
    end
  end

  // end_q marks the write cycle of a packet's final byte; release happens after it.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    abort_d  = 1'b0;
    end_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (end_q) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_q;
        end else if (xfer) begin
          wr_d    = 1'b1;
          data_d  = sel_data;
          cnt_d   = cnt_inc;
          end_d   = sel_last | at_max;
          abort_d = ~sel_last & at_max;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Blocking on wr_q enforces the one-byte-per-two-clocks pacing.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_XFER) begin
      req_ready[grant_q] = ~tx_buffer_full & ~wr_q;
    end
  end

  assign busy          = (state_q == ST_XFER);
  assign grant_id      = grant_q;
  assign write_tx_data = wr_q;
  assign tx_data_in    = data_q;
  assign pkt_abort     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues drive the inputs,
// a scoreboard of {grant, byte} is checked on every write strobe.
module tb_uart_tx_arbiter;
  localparam int NR   = 4;
  localparam int MAXP = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [7:0]        tx_data_in;
  logic              write_tx_data;
  logic              tx_buffer_full;
  logic [1:0]        grant_id;
  logic              busy;
  logic              pkt_abort;

  int checks = 0;
  int errors = 0;

  logic [8:0]    src_q [NR][$];
  logic [9:0]    exp_q [$];
  logic [NR-1:0] hold;
  int            cycle     = 0;
  int            last_wr   = -100;
  int            wr_cnt    = 0;
  int            abort_cnt = 0;
  logic          abort_prev = 1'b0;
  logic [7:0]    last_byte  = 8'h00;

  uart_tx_arbiter #(.N_REQ(NR), .MAX_PKT_LEN(MAXP)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .tx_data_in     (tx_data_in),
    .write_tx_data  (write_tx_data),
    .tx_buffer_full (tx_buffer_full),
    .grant_id       (grant_id),
    .busy           (busy),
    .pkt_abort      (pkt_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int id, input int len, input logic [7:0] base, input bit last_at_end);
    logic [7:0] b;
    logic       l;
    for (int k = 0; k < len; k++) begin
      b = base + 8'(k);
      l = last_at_end && (k == len - 1);
      src_q[id].push_back({l, b});
      exp_q.push_back({2'(id), b});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, write_tx_data, 1'b0);
    chk({tag, "_data"},  tx_data_in,    8'h00);
    chk({tag, "_ready"}, req_ready,     4'h0);
    chk({tag, "_grant"}, grant_id,      2'd0);
    chk({tag, "_busy"},  busy,          1'b0);
    chk({tag, "_abort"}, pkt_abort,     1'b0);
  endtask

  task automatic clear_tb_state();
    last_wr    = -100;
    abort_prev = 1'b0;
    last_byte  = 8'h00;
  endtask

  // One clock: sample handshakes before the edge, inspect outputs 1 time unit after it.
  task automatic tick();
    logic [NR-1:0] hs;
    logic [9:0]    e;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    if (abort_prev) chk("idle_after_abort", busy, 1'b0);
    abort_prev = pkt_abort;
    if (pkt_abort) begin
      abort_cnt++;
      chk("abort_in_write_cycle", write_tx_data, 1'b1);
    end
    if (write_tx_data) begin
      wr_cnt++;
      chk("write_gap_ge2", 32'(cycle - last_wr >= 2), 1);
      last_wr = cycle;
      if (exp_q.size() == 0) begin
        chk("write_without_expectation", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", tx_data_in, e[7:0]);
        chk("grant_at_write", grant_id, e[9:8]);
        last_byte = e[7:0];
      end
    end else begin
      chk("tx_data_hold", tx_data_in, last_byte);
    end
    drive_inputs();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_completed_in_budget"}, 32'(n < budget), 1);
  endtask

  initial begin
    int w0;
    int a0;
    int n;

    reset          = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    req_last       = '0;
    tx_buffer_full = 1'b0;
    hold           = '0;

    // Reset state.
    #2 reset = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // Single packet from requester 2.
    w0 = wr_cnt;
    load_pkt(2, 3, 8'h41, 1'b1);
    drive_inputs();
    run_until_done(100, "single");
    chk("single_write_count", wr_cnt - w0, 3);
    chk("single_busy_after", busy, 1'b0);
    chk("single_grant_id", grant_id, 2'd2);

    // Contention from reset: 0, 1, 3 in pointer order, never interleaved.
    @(negedge clk) reset = 1'b1;
    #1;
    check_reset_outputs("reset2");
    clear_tb_state();
    @(negedge clk) reset = 1'b0;
    load_pkt(0, 2, 8'h10, 1'b1);
    load_pkt(1, 2, 8'h20, 1'b1);
    load_pkt(3, 2, 8'h30, 1'b1);
    drive_inputs();
    run_until_done(200, "contention");

    // Backpressure: buffer full for 50 cycles mid-packet.
    w0 = wr_cnt;
    load_pkt(2, 4, 8'h50, 1'b1);
    drive_inputs();
    n = 0;
    while (wr_cnt == w0 && n < 20) begin tick(); n++; end
    chk("bp_first_write_seen", wr_cnt - w0, 1);
    tx_buffer_full = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("bp_ready_low", req_ready, 4'h0);
      chk("bp_no_write", write_tx_data, 1'b0);
    end
    tx_buffer_full = 1'b0;
    run_until_done(100, "backpressure");
    chk("bp_write_count", wr_cnt - w0, 4);

    // Overlong packet from requester 1, then requester 3 takes over.
    w0 = wr_cnt;
    a0 = abort_cnt;
    load_pkt(1, MAXP, 8'h00, 1'b0);
    drive_inputs();
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk("long_granted", grant_id, 2'd1);
    load_pkt(3, 1, 8'h77, 1'b1);
    drive_inputs();
    run_until_done(2000, "overlong");
    chk("long_write_count", wr_cnt - w0, MAXP + 1);
    chk("long_abort_count", abort_cnt - a0, 1);

    // Asynchronous reset after 5 bytes of a 10-byte packet.
    w0 = wr_cnt;
    load_pkt(2, 10, 8'h60, 1'b1);
    drive_inputs();
    n = 0;
    while (wr_cnt - w0 < 5 && n < 100) begin tick(); n++; end
    chk("rst_five_writes", wr_cnt - w0, 5);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midpkt_reset");
    src_q[2].delete();
    exp_q.delete();
    clear_tb_state();
    load_pkt(0, 1, 8'h99, 1'b1);
    load_pkt(2, 2, 8'hA0, 1'b1);
    drive_inputs();
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("in_reset_no_write", write_tx_data, 1'b0);
      chk("in_reset_idle", busy, 1'b0);
    end
    @(negedge clk) reset = 1'b0;
    run_until_done(100, "after_reset");

    // Stall: granted requester 3 drops valid while requester 0 waits.
    w0 = wr_cnt;
    load_pkt(3, 4, 8'hC0, 1'b1);
    drive_inputs();
    n = 0;
    while (wr_cnt - w0 < 2 && n < 50) begin tick(); n++; end
    chk("stall_two_writes", wr_cnt - w0, 2);
    hold[3] = 1'b1;
    load_pkt(0, 1, 8'hD0, 1'b1);
    drive_inputs();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("stall_grant_held", grant_id, 2'd3);
      chk("stall_req0_waits", req_ready[0], 1'b0);
      chk("stall_no_write", write_tx_data, 1'b0);
      chk("stall_busy", busy, 1'b1);
    end
    hold[3] = 1'b0;
    drive_inputs();
    run_until_done(100, "stall");

    chk("abort_total", abort_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
